// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl
//   Raster timing sequencer. Free-running h/v counters on pixel_clock drive
//   registered sync, blank, pixel coordinates and line/frame strobes. Run/stop
//   takes effect only at frame boundaries, so no truncated frame is ever sent.
//
// Ports
//   pixel_clock  in   pixel clock (only clock)
//   reset_n      in   asynchronous active-low reset
//   run          in   raster enable, sampled every clock
//   h_synch      out  horizontal sync (asserted level HS_POL)
//   v_synch      out  vertical sync (asserted level VS_POL)
//   blank        out  1 outside active area or when idle
//   pixel_x/y    out  active-area coordinates, hold last value while blanked
//   line_start   out  pulse at h=0 of each line while busy
//   frame_start  out  pulse at h=0, v=0
//   busy         out  1 in RUN or STOPPING
//   fetch_req    out  (VTIMING_PREFETCH_EN) fetch strobe, 2 clocks ahead of blank=0
//   fetch_x      out  (VTIMING_PREFETCH_EN) column to fetch
//
// Optional feature macro: VTIMING_PREFETCH_EN
//   Defined   -> fetch_req / fetch_x ports and lookahead logic exist.
//   Undefined -> those ports and that logic are absent.
//
// All outputs are registered from the current counter value, so they lag the
// counters by one clock.

module video_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       pixel_clock,
    input  logic       reset_n,
    input  logic       run,
    output logic       h_synch,
    output logic       v_synch,
    output logic       blank,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       busy
`ifdef VTIMING_PREFETCH_EN
    ,
    output logic       fetch_req,
    output logic [9:0] fetch_x
`endif
);

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_TOT  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_TOT  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t      state, state_nxt;
    logic [10:0] h_cnt, v_cnt;
    logic        h_last, v_last, frame_end;

    assign h_last    = (h_cnt == H_TOT - 11'd1);
    assign v_last    = (v_cnt == V_TOT - 11'd1);
    assign frame_end = h_last && v_last;

    // ---- state register ----
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---- next state ----
    // At the last clock of a frame the run sample alone picks continue/idle,
    // whether the frame was running or already stopping.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (run) state_nxt = RUN;
            RUN:      if (frame_end) state_nxt = run ? RUN : IDLE;
                      else if (!run) state_nxt = STOPPING;
            STOPPING: if (run) state_nxt = RUN;
                      else if (frame_end) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // ---- counters: held at 0 in IDLE; the wrap at frame end also yields 0
    // when dropping to IDLE ----
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // ---- output decode ----
    logic       hs_d, vs_d, blank_d, ls_d, fs_d, busy_d;
    logic [9:0] px_d, py_d;
    logic       active;

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    always_comb begin
        hs_d    = ~HS_POL;
        vs_d    = ~VS_POL;
        blank_d = 1'b1;
        px_d    = pixel_x;
        py_d    = pixel_y;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        busy_d  = 1'b0;
        if (state == IDLE) begin
            px_d = '0;
            py_d = '0;
        end else begin
            busy_d = 1'b1;
            ls_d   = (h_cnt == 11'd0);
            fs_d   = (h_cnt == 11'd0) && (v_cnt == 11'd0);
            if (active) begin
                blank_d = 1'b0;
                px_d    = h_cnt[9:0];
                py_d    = v_cnt[9:0];
            end
            if (h_cnt >= H_SS && h_cnt < H_SE) hs_d = HS_POL;
            if (v_cnt >= V_SS && v_cnt < V_SE) vs_d = VS_POL;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_synch     <= ~HS_POL;
            v_synch     <= ~VS_POL;
            blank       <= 1'b1;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            h_synch     <= hs_d;
            v_synch     <= vs_d;
            blank       <= blank_d;
            pixel_x     <= px_d;
            pixel_y     <= py_d;
            line_start  <= ls_d;
            frame_start <= fs_d;
            busy        <= busy_d;
        end
    end

`ifdef VTIMING_PREFETCH_EN
    // Lookahead position = counters + 2, wrapping across line and frame, so
    // the fetch strobe leads the matching blank=0 output by two clocks.
    logic [10:0] la_h, la_v;
    logic        la_active;

    always_comb begin
        if (h_cnt >= H_TOT - 11'd2) begin
            la_h = h_cnt - (H_TOT - 11'd2);
            la_v = v_last ? 11'd0 : v_cnt + 11'd1;
        end else begin
            la_h = h_cnt + 11'd2;
            la_v = v_cnt;
        end
    end

    assign la_active = (la_h < H_ACT) && (la_v < V_ACT);

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_req <= 1'b0;
            fetch_x   <= '0;
        end else if (state == IDLE) begin
            fetch_req <= 1'b0;
            fetch_x   <= '0;
        end else begin
            fetch_req <= la_active;
            if (la_active) fetch_x <= la_h[9:0];
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl using a reduced raster so whole frames
// fit in a short run: H = 8+2+3+3 = 16 clocks, V = 6+1+2+2 = 11 lines,
// frame = 176 clocks. h_synch low for h=10..12, v_synch low for v=7..8.
// Outputs are sampled 1 time unit after each rising edge.

module tb_video_timing_ctrl;

    logic       pixel_clock;
    logic       reset_n;
    logic       run;
    logic       h_synch, v_synch, blank, line_start, frame_start, busy;
    logic [9:0] pixel_x, pixel_y;
`ifdef VTIMING_PREFETCH_EN
    logic       fetch_req;
    logic [9:0] fetch_x;
`endif

    video_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .run         (run),
        .h_synch     (h_synch),
        .v_synch     (v_synch),
        .blank       (blank),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .busy        (busy)
`ifdef VTIMING_PREFETCH_EN
        ,
        .fetch_req   (fetch_req),
        .fetch_x     (fetch_x)
`endif
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    int tests = 0;
    int fails = 0;

    // event monitors, all updated from the single stimulus process
    int cyc = 0;
    int fs_cnt, ls_cnt, act_cnt, hs_lo, vs_lo, busy_hi, busy_lo;
    int fs_last = 0, fs_prev = 0, ls_last = 0, hs_off = -1, busy_fall = 0;
    logic hs_prev = 1'b1, busy_prev = 1'b0;
    int pf_base = 0;
    int c0, f2, g0, h0, r0, j0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        fs_cnt = 0; ls_cnt = 0; act_cnt = 0; hs_lo = 0; vs_lo = 0;
        busy_hi = 0; busy_lo = 0;
    endtask

    task automatic clk1();
        @(posedge pixel_clock);
        #1;
        cyc++;
        if (frame_start === 1'b1) begin fs_cnt++; fs_prev = fs_last; fs_last = cyc; end
        if (line_start === 1'b1) begin ls_cnt++; ls_last = cyc; end
        if (blank === 1'b0) act_cnt++;
        if (h_synch === 1'b0) hs_lo++;
        if (h_synch === 1'b0 && hs_prev === 1'b1) hs_off = cyc - ls_last;
        hs_prev = h_synch;
        if (v_synch === 1'b0) vs_lo++;
        if (busy === 1'b1) busy_hi++; else busy_lo++;
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall = cyc;
        busy_prev = busy;
`ifdef VTIMING_PREFETCH_EN
        // fetch at frame offset k targets the pixel shown at offset k+2
        if (pf_base > 0) begin
            case (cyc - pf_base)
                14:  begin chk("pf_req_l1x0", fetch_req, 1); chk("pf_x_l1x0", fetch_x, 0); end
                21:  begin chk("pf_req_l1x7", fetch_req, 1); chk("pf_x_l1x7", fetch_x, 7); end
                22:  chk("pf_req_l1x8", fetch_req, 0);
                96:  chk("pf_req_l6", fetch_req, 0);
                174: begin chk("pf_req_wrap", fetch_req, 1); chk("pf_x_wrap", fetch_x, 0); end
                default: ;
            endcase
        end
`endif
    endtask

    task automatic run_to(input int target);
        while (cyc < target) clk1();
    endtask

    initial begin
        run     = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        // ---- reset state ----
        chk("rst_busy", busy, 0);
        chk("rst_blank", blank, 1);
        chk("rst_hs", h_synch, 1);
        chk("rst_vs", v_synch, 1);
        chk("rst_px", pixel_x, 0);
        chk("rst_py", pixel_y, 0);
        chk("rst_ls", line_start, 0);
        chk("rst_fs", frame_start, 0);
        repeat (3) clk1();
        reset_n = 1'b1;

        // ---- idle with run=0 ----
        clr();
        repeat (60) clk1();
        chk("idle_busy_hi", busy_hi, 0);
        chk("idle_act", act_cnt, 0);
        chk("idle_hs_lo", hs_lo, 0);
        chk("idle_vs_lo", vs_lo, 0);
        chk("idle_fs", fs_cnt, 0);
        chk("idle_ls", ls_cnt, 0);

        // ---- one full frame ----
        run = 1'b1;
        c0 = cyc;
        clr();
        clk1();
        chk("start_fs_early", frame_start, 0);
        clk1();
        chk("start_fs", frame_start, 1);
        chk("start_fs_time", fs_last - c0, 2);
        while (cyc < c0 + 177) begin
            clk1();
            case (cyc - (c0 + 2))
                16*2+3: begin chk("px_3_2", pixel_x, 3); chk("py_3_2", pixel_y, 2); chk("bl_3_2", blank, 0); end
                16*5+7: begin chk("px_7_5", pixel_x, 7); chk("py_7_5", pixel_y, 5); chk("bl_7_5", blank, 0); end
                16*5+8: begin chk("bl_8_5", blank, 1); chk("px_hold", pixel_x, 7); end
                16*6:   begin chk("bl_v6", blank, 1); chk("py_hold", pixel_y, 5); chk("vs_v6", v_synch, 1); end
                16*7:   chk("vs_v7", v_synch, 0);
                16*8+15: chk("vs_v8_end", v_synch, 0);
                16*9:   chk("vs_v9", v_synch, 1);
                default: ;
            endcase
        end
        chk("f1_act", act_cnt, 48);
        chk("f1_ls", ls_cnt, 11);
        chk("f1_fs", fs_cnt, 1);
        chk("f1_hs_lo", hs_lo, 33);
        chk("f1_vs_lo", vs_lo, 32);
        chk("f1_hs_off", hs_off, 10);
        chk("f1_ls_period", ls_last - fs_last, 160);

        // ---- second frame: stop requested at v=3 ----
        clr();
        clk1();
        f2 = cyc;
        chk("f2_fs", frame_start, 1);
        chk("f2_period", fs_last - fs_prev, 176);
        run_to(f2 + 48);
        run = 1'b0;
        run_to(f2 + 248);
        chk("stop_busy_fall", busy_fall - f2, 176);
        chk("stop_act", act_cnt, 48);
        chk("stop_ls", ls_cnt, 11);
        chk("stop_fs", fs_cnt, 1);
        chk("stop_busy", busy, 0);
        chk("stop_blank", blank, 1);
        chk("stop_hs", h_synch, 1);

        // ---- drop at v=2, re-raise at v=4: no gap ----
        run = 1'b1;
        clk1();
        clk1();
        g0 = cyc;
        chk("t3_fs", frame_start, 1);
        clr();
        run_to(g0 + 32);
        run = 1'b0;
        run_to(g0 + 64);
        run = 1'b1;
        run_to(g0 + 176);
        chk("t3_fs_next", frame_start, 1);
        chk("t3_period", fs_last - fs_prev, 176);
        chk("t3_busy_lo", busy_lo, 0);

        // ---- asynchronous reset mid-frame at (5,3) ----
        h0 = cyc;
        run_to(h0 + 53);
        chk("mid_px_pre", pixel_x, 5);
        chk("mid_py_pre", pixel_y, 3);
        reset_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_blank", blank, 1);
        chk("mid_px", pixel_x, 0);
        chk("mid_py", pixel_y, 0);
        chk("mid_hs", h_synch, 1);
        chk("mid_vs", v_synch, 1);
        clr();
        repeat (3) clk1();
        reset_n = 1'b1;
        r0 = cyc;
        clk1();
        clk1();
        j0 = cyc;
        chk("rec_fs", frame_start, 1);
        chk("rec_fs_cnt", fs_cnt, 1);
        chk("rec_fs_time", fs_last - r0, 2);

        // ---- stop, then re-raise on the final clock of the frame ----
        clr();
        pf_base = j0;
        run_to(j0 + 100);
        run = 1'b0;
        run_to(j0 + 174);
        run = 1'b1;
        run_to(j0 + 176);
        chk("last_fs", frame_start, 1);
        chk("last_period", fs_last - fs_prev, 176);
        chk("last_busy_lo", busy_lo, 0);
        pf_base = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
Raster timing sequencer for the video output stage. Runs horizontal and vertical counters on the pixel clock and issues h_synch, v_synch and blank to the video output register, plus pixel coordinates and frame/line strobes to the pixel source. Run/stop control is applied only at frame boundaries, so the monitor never receives a truncated frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of h_synch
VS_POL, 0, asserted level of v_synch

Ports:
pixel_clock  in  1  pixel clock; the only clock
reset_n  in  1  asynchronous, active-low reset
run  in  1  request raster generation; sampled every clock
h_synch  out  1  horizontal sync, registered
v_synch  out  1  vertical sync, registered
blank  out  1  1 outside the active area or when not running
pixel_x  out  10  active-area column, 0..H_ACTIVE-1
pixel_y  out  10  active-area row, 0..V_ACTIVE-1
line_start  out  1  one-clock pulse at h=0 of every line in RUN/STOPPING
frame_start  out  1  one-clock pulse at h=0, v=0
busy  out  1  1 in RUN or STOPPING

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Internal counters h_cnt and v_cnt are each 11 bits.
- Reset (reset_n=0, asynchronous):
  - h_synch=~HS_POL, v_synch=~VS_POL, blank=1
  - pixel_x=0, pixel_y=0, line_start=0, frame_start=0, busy=0
  - counters=0, state=IDLE
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: counters held at 0; outputs at their reset values. run=1 moves to RUN; the counters start at (0,0) on the next clock.
  - RUN: h_cnt increments each clock. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1. run=0 moves to STOPPING and the counters keep advancing.
  - STOPPING: counters continue. If run returns to 1 before the frame ends, go back to RUN with no counter disturbance. Otherwise, at h=H_TOTAL-1 and v=V_TOTAL-1, go to IDLE; the counters are 0 on the next clock and the outputs take their idle values.
- Output decode: all outputs are registered from the current counter value, so they appear 1 clock after the counters hold (h,v).
  - Active area: h<H_ACTIVE and v<V_ACTIVE. There, blank=0, pixel_x=h and pixel_y=v.
  - Outside the active area, blank=1 and pixel_x/pixel_y hold their last active values.
  - h_synch=HS_POL for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - v_synch=VS_POL for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491), over whole lines.
- The pixel source must present colour data 1 clock after pixel_x/pixel_y; the output stage adds 1 further register.
- Simultaneous events: run toggling at the final frame clock. The run value sampled on that clock decides RUN (continue) or IDLE.
- Reset mid-frame forces IDLE immediately. No partial-frame recovery.

Optional Feature:
VTIMING_PREFETCH_EN.
- Defined: adds output fetch_req (1 bit) and fetch_x (10 bits), generated 2 clocks ahead of the pixel_x/blank timing.
  - fetch_req=1 exactly when the counters are at h+2 with h in the active area, including wrap into the next line.
  - This lets a synchronous RAM plus attribute lookup land data aligned with blank=0.
  - Reset values: fetch_req=0, fetch_x=0.
- Undefined: the ports are absent and no extra logic is generated.

Test Plan:
- Reset release with run=0 for 1000 clocks → busy=0, blank=1, h_synch=1, v_synch=1, no strobes.
- run=1 held for one full frame → frame_start period = 420000 clocks; line_start period = 800 clocks; blank=0 for 640 clocks per line on lines 0..479; h_synch low for 96 clocks starting 656 clocks after line_start; v_synch low for lines 490-491 only.
- run dropped at v=100 → raster continues to h=799, v=524; busy falls 1 clock later; no further frame_start.
- run dropped at v=200 and re-raised at v=300 → no gap; next frame_start exactly 420000 clocks after the previous one.
- reset_n pulsed low at h=300, v=50 → outputs return to reset values asynchronously; after release with run=1, the first frame_start is 1 clock after the RUN entry.
- With VTIMING_PREFETCH_EN: fetch_x=0 is asserted 2 clocks before pixel_x=0/blank=0 on every active line; fetch_req=0 throughout lines 480..524.
